// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Bridges the MEM stage of the CPU pipeline to the MIO bus. An aligned
// load/store presented by the MEM stage is latched and driven onto the bus
// until the bus completes it (MIO_ready) or a wait budget expires. While the
// access is pending the whole pipeline is frozen through mem_stall. Misaligned
// accesses and bus timeouts produce a one-cycle mem_err pulse. No bus cycle is
// started for a misaligned access.
//
// Parameters
//   TIMEOUT_CYCLES  REQ-state cycles allowed without MIO_ready (1..255)
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous, active-low reset
//   mem_req    in   1   MEM stage holds a valid load/store
//   mem_we     in   1   1 = store, 0 = load
//   mem_addr   in   32  byte address from the MEM stage
//   mem_wdata  in   32  store data
//   mem_rdata  out  32  load data towards MEM/WB
//   mem_stall  out  1   pipeline freeze (combinational)
//   CPU_MIO    out  1   bus request
//   bus_we     out  1   bus write strobe, only high together with CPU_MIO
//   bus_addr   out  32  latched bus address
//   bus_wdata  out  32  latched bus write data
//   MIO_ready  in   1   bus completion handshake
//   Data_in    in   32  bus read data, valid with MIO_ready
//   mem_err    out  1   one-cycle pulse: misaligned access or bus timeout
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        CPU_MIO,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        MIO_ready,
  input  logic [31:0] Data_in,
  output logic        mem_err
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WAIT_W = 8;

  // The counter holds the number of REQ cycles already completed, so the
  // cycle that exhausts the budget sees TIMEOUT_CYCLES-1.
  localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t              stateCur;
  state_t              stateNxt;
  logic [WAIT_W-1:0]   waitCnt;
  logic [DATA_W-1:0]   addrLatch;
  logic [DATA_W-1:0]   wdataLatch;
  logic                weLatch;
  logic [DATA_W-1:0]   rdataReg;
  logic                aligned;
  logic                timeoutHit;

  // Saturating increment: the wait counter must never wrap back to zero.
  function automatic logic [WAIT_W-1:0] satInc(input logic [WAIT_W-1:0] v);
    if (v == {WAIT_W{1'b1}}) begin
      return v;
    end
    return v + WAIT_W'(1);
  endfunction

  function automatic logic budgetSpent(input logic [WAIT_W-1:0] v);
    return (v >= TIMEOUT_LAST);
  endfunction

  assign aligned    = (mem_addr[1:0] == 2'b00);
  assign timeoutHit = budgetSpent(waitCnt);

  // Next-state logic. MIO_ready is tested before the timeout so a completion
  // in the very cycle the budget runs out still counts as success.
  always_comb begin
    stateNxt = stateCur;
    unique case (stateCur)
      IDLE: begin
        if (mem_req) begin
          stateNxt = aligned ? REQ : ERR;
        end
      end
      REQ: begin
        if (MIO_ready) begin
          stateNxt = DONE;
        end else if (timeoutHit) begin
          stateNxt = ERR;
        end
      end
      DONE:    stateNxt = IDLE;
      ERR:     stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // State and datapath registers. Everything visible on the ports is cleared
  // by the asynchronous reset so outputs drop without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateCur   <= IDLE;
      waitCnt    <= '0;
      addrLatch  <= '0;
      wdataLatch <= '0;
      weLatch    <= 1'b0;
      rdataReg   <= '0;
    end else begin
      stateCur <= stateNxt;
      unique case (stateCur)
        IDLE: begin
          if (mem_req && aligned) begin
            addrLatch  <= mem_addr;
            wdataLatch <= mem_wdata;
            weLatch    <= mem_we;
            waitCnt    <= '0;
          end
        end
        REQ: begin
          waitCnt <= satInc(waitCnt);
          if (MIO_ready && !weLatch) begin
            rdataReg <= Data_in;
          end
        end
        default: ;
      endcase
      // Failed accesses deliver zero to the pipeline during the ERR cycle.
      if (stateNxt == ERR) begin
        rdataReg <= '0;
      end
    end
  end

  // Outputs: registered values or pure state decodes, except mem_stall which
  // must react to mem_req in the same cycle it is raised.
  assign CPU_MIO   = (stateCur == REQ);
  assign bus_we    = weLatch && (stateCur == REQ);
  assign bus_addr  = addrLatch;
  assign bus_wdata = wdataLatch;
  assign mem_rdata = rdataReg;
  assign mem_err   = (stateCur == ERR);
  assign mem_stall = rst && (((stateCur == IDLE) && mem_req) || (stateCur == REQ));

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Directed bench for mem_access_ctrl: a per-cycle vector table for the basic
// load / store / misaligned / back-to-back flows, followed by hand-written
// sequences for timeout, the ready-at-timeout tie and reset during REQ.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        CPU_MIO;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        MIO_ready;
  logic [31:0] Data_in;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_stall (mem_stall),
    .CPU_MIO   (CPU_MIO),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .MIO_ready (MIO_ready),
    .Data_in   (Data_in),
    .mem_err   (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] din;
    logic        eStall;
    logic        eCpu;
    logic        eBusWe;
    logic [31:0] eBusAddr;
    logic [31:0] eBusWdata;
    logic        eErr;
    logic [31:0] eRdata;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic req, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic ready, input logic [31:0] din,
                              input logic eStall, input logic eCpu, input logic eBusWe,
                              input logic [31:0] eBusAddr, input logic [31:0] eBusWdata,
                              input logic eErr, input logic [31:0] eRdata);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.wdata = wdata; v.ready = ready; v.din = din;
    v.eStall = eStall; v.eCpu = eCpu; v.eBusWe = eBusWe; v.eBusAddr = eBusAddr;
    v.eBusWdata = eBusWdata; v.eErr = eErr; v.eRdata = eRdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to one time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic ready, input logic [31:0] din);
    mem_req = req; mem_we = we; mem_addr = addr; mem_wdata = wdata;
    MIO_ready = ready; Data_in = din;
  endtask

  initial begin
    int cnt;
    string tag;

    // -------- reset --------
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'h0);
    #2;
    chk("reset_stall", {31'b0, mem_stall}, 32'd0);
    chk("reset_cpu_mio", {31'b0, CPU_MIO}, 32'd0);
    chk("reset_bus_we", {31'b0, bus_we}, 32'd0);
    chk("reset_bus_addr", bus_addr, 32'h0);
    chk("reset_bus_wdata", bus_wdata, 32'h0);
    chk("reset_rdata", mem_rdata, 32'h0);
    chk("reset_err", {31'b0, mem_err}, 32'd0);
    mem_req = 1'b0;
    #20;
    rst = 1'b1;
    step();

    // -------- vector table --------
    // load 0x10, ready on the 3rd REQ cycle
    vecs[0]  = mk(1, 0, 32'h10, 32'h0, 0, 32'h0,         1, 0, 0, 32'h0,  32'h0,         0, 32'h0);
    vecs[1]  = mk(1, 0, 32'h10, 32'h0, 0, 32'h0,         1, 1, 0, 32'h10, 32'h0,         0, 32'h0);
    vecs[2]  = mk(1, 0, 32'h10, 32'h0, 0, 32'h0,         1, 1, 0, 32'h10, 32'h0,         0, 32'h0);
    vecs[3]  = mk(1, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF,  1, 1, 0, 32'h10, 32'h0,         0, 32'h0);
    vecs[4]  = mk(0, 0, 32'h0,  32'h0, 0, 32'h0,         0, 0, 0, 32'h0,  32'h0,         0, 32'hDEADBEEF);
    vecs[5]  = mk(0, 0, 32'h0,  32'h0, 0, 32'h0,         0, 0, 0, 32'h0,  32'h0,         0, 32'hDEADBEEF);
    // store 0x20, ready tied high, bus data must not reach mem_rdata
    vecs[6]  = mk(1, 1, 32'h20, 32'h12345678, 1, 32'hFFFFFFFF, 1, 0, 0, 32'h0,  32'h0,         0, 32'hDEADBEEF);
    vecs[7]  = mk(1, 1, 32'h20, 32'h12345678, 1, 32'hFFFFFFFF, 1, 1, 1, 32'h20, 32'h12345678,  0, 32'hDEADBEEF);
    vecs[8]  = mk(0, 0, 32'h0,  32'h0,        1, 32'hFFFFFFFF, 0, 0, 0, 32'h0,  32'h0,         0, 32'hDEADBEEF);
    // misaligned load 0x13
    vecs[9]  = mk(1, 0, 32'h13, 32'h0, 1, 32'h11111111,  1, 0, 0, 32'h0,  32'h0,         0, 32'hDEADBEEF);
    vecs[10] = mk(0, 0, 32'h0,  32'h0, 1, 32'h11111111,  0, 0, 0, 32'h0,  32'h0,         1, 32'h0);
    vecs[11] = mk(0, 0, 32'h0,  32'h0, 1, 32'h11111111,  0, 0, 0, 32'h0,  32'h0,         0, 32'h0);
    // back-to-back loads, ready tied high, second held through DONE
    vecs[12] = mk(1, 0, 32'h40, 32'h0, 1, 32'hA5A50001,  1, 0, 0, 32'h0,  32'h0,         0, 32'h0);
    vecs[13] = mk(1, 0, 32'h40, 32'h0, 1, 32'hA5A50001,  1, 1, 0, 32'h40, 32'h0,         0, 32'h0);
    vecs[14] = mk(1, 0, 32'h44, 32'h0, 1, 32'h5A5A0002,  0, 0, 0, 32'h0,  32'h0,         0, 32'hA5A50001);
    vecs[15] = mk(1, 0, 32'h44, 32'h0, 1, 32'h5A5A0002,  1, 0, 0, 32'h0,  32'h0,         0, 32'hA5A50001);
    vecs[16] = mk(1, 0, 32'h44, 32'h0, 1, 32'h5A5A0002,  1, 1, 0, 32'h44, 32'h0,         0, 32'hA5A50001);
    vecs[17] = mk(0, 0, 32'h0,  32'h0, 1, 32'h0,         0, 0, 0, 32'h0,  32'h0,         0, 32'h5A5A0002);

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ready, vecs[i].din);
      #2;
      tag = $sformatf("vec%0d", i);
      chk({tag, "_stall"},  {31'b0, mem_stall}, {31'b0, vecs[i].eStall});
      chk({tag, "_cpu_mio"}, {31'b0, CPU_MIO},  {31'b0, vecs[i].eCpu});
      chk({tag, "_bus_we"}, {31'b0, bus_we},    {31'b0, vecs[i].eBusWe});
      chk({tag, "_err"},    {31'b0, mem_err},   {31'b0, vecs[i].eErr});
      chk({tag, "_rdata"},  mem_rdata,          vecs[i].eRdata);
      if (vecs[i].eCpu) begin
        chk({tag, "_bus_addr"},  bus_addr,  vecs[i].eBusAddr);
        chk({tag, "_bus_wdata"}, bus_wdata, vecs[i].eBusWdata);
      end
      step();
    end

    // -------- timeout: ready never comes --------
    drive(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 32'h77777777);
    step();
    cnt = 0;
    while (CPU_MIO && cnt < 40) begin
      cnt++;
      step();
    end
    mem_req = 1'b0;
    #1;
    chk("timeout_cpu_mio_cycles", cnt, 32'd15);
    chk("timeout_err", {31'b0, mem_err}, 32'd1);
    chk("timeout_stall", {31'b0, mem_stall}, 32'd0);
    chk("timeout_rdata", mem_rdata, 32'h0);
    step();
    chk("timeout_err_cleared", {31'b0, mem_err}, 32'd0);
    // next request completes normally
    drive(1'b1, 1'b0, 32'h88, 32'h0, 1'b1, 32'h0BADF00D);
    step();
    chk("after_timeout_cpu", {31'b0, CPU_MIO}, 32'd1);
    step();
    mem_req = 1'b0;
    #1;
    chk("after_timeout_rdata", mem_rdata, 32'h0BADF00D);
    chk("after_timeout_err", {31'b0, mem_err}, 32'd0);
    step();

    // -------- ready arrives in the cycle the budget expires --------
    drive(1'b1, 1'b0, 32'h84, 32'h0, 1'b0, 32'h0);
    step();
    repeat (14) step();
    MIO_ready = 1'b1;
    Data_in   = 32'hCAFEF00D;
    #1;
    chk("tie_cpu_15th", {31'b0, CPU_MIO}, 32'd1);
    step();
    mem_req = 1'b0;
    MIO_ready = 1'b0;
    #1;
    chk("tie_err", {31'b0, mem_err}, 32'd0);
    chk("tie_rdata", mem_rdata, 32'hCAFEF00D);
    chk("tie_cpu_done", {31'b0, CPU_MIO}, 32'd0);
    step();

    // -------- reset in the 2nd REQ cycle --------
    drive(1'b1, 1'b1, 32'h100, 32'h55AA55AA, 1'b0, 32'h0);
    step();
    step();
    chk("midreq_cpu_before", {31'b0, CPU_MIO}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("midreq_cpu", {31'b0, CPU_MIO}, 32'd0);
    chk("midreq_stall", {31'b0, mem_stall}, 32'd0);
    chk("midreq_bus_we", {31'b0, bus_we}, 32'd0);
    chk("midreq_bus_addr", bus_addr, 32'h0);
    chk("midreq_bus_wdata", bus_wdata, 32'h0);
    chk("midreq_rdata", mem_rdata, 32'h0);
    chk("midreq_err", {31'b0, mem_err}, 32'd0);
    mem_req = 1'b0;
    step();
    #2;
    rst = 1'b1;
    MIO_ready = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("post_reset%0d_cpu", k), {31'b0, CPU_MIO}, 32'd0);
      chk($sformatf("post_reset%0d_err", k), {31'b0, mem_err}, 32'd0);
      chk($sformatf("post_reset%0d_stall", k), {31'b0, mem_stall}, 32'd0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
